// File: rtl/uart_alu_interface.sv
// Command sequencer behind the UART receiver: gathers A, B and opcode words,
// drives an external ALU and hands the result to the transmitter. Option: RX_TIMEOUT_EN.
module uart_alu_interface #(
    parameter int NB_DATA        = 16,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_rx_overrun,
    output logic               o_timeout
);

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_SEND,
        S_WAIT_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [NB_DATA-1:0] a_q, a_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] tx_q, tx_d;
    logic               ovr_q, ovr_d;
    logic               busy;
    logic               tmo_hit;

    assign busy = (state_q == S_EXEC) || (state_q == S_SEND) ||
                  (state_q == S_WAIT_DONE);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        tx_d    = tx_q;
        // words landing while busy are dropped, never queued
        ovr_d   = ovr_q | (busy & i_rx_valid);
        unique case (state_q)
            S_WAIT_A: begin
                if (i_rx_valid) begin
                    a_d     = i_rx_data;
                    state_d = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (i_rx_valid) begin
                    b_d     = i_rx_data;
                    state_d = S_WAIT_OP;
                end else if (tmo_hit) begin
                    state_d = S_WAIT_A;
                end
            end
            S_WAIT_OP: begin
                if (i_rx_valid) begin
                    op_d    = i_rx_data[NB_OP-1:0];
                    state_d = S_EXEC;
                end else if (tmo_hit) begin
                    state_d = S_WAIT_A;
                end
            end
            S_EXEC: begin
                tx_d    = i_alu_result;
                state_d = S_SEND;
            end
            S_SEND: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_tx_done) begin
                    state_d = S_WAIT_A;
                end
            end
            default: begin
                state_d = S_WAIT_A;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            tx_q    <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            tx_q    <= tx_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting;
    logic             to_q;

    assign waiting = (state_q == S_WAIT_B) || (state_q == S_WAIT_OP);
    assign tmo_hit = waiting && (cnt_q == CNT_LAST);

    // zero outside WAIT_B/WAIT_OP, so re-entry always starts from 0
    always_comb begin
        cnt_d = '0;
        if (waiting && !i_rx_valid && !tmo_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= tmo_hit && !i_rx_valid;
        end
    end

    assign o_timeout = to_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign tmo_hit            = 1'b0;
    assign o_timeout          = 1'b0;
`endif

    assign o_alu_a      = a_q;
    assign o_alu_b      = b_q;
    assign o_alu_op     = op_q;
    assign o_tx_data    = tx_q;
    assign o_tx_start   = (state_q == S_SEND);
    assign o_busy       = busy;
    assign o_rx_overrun = ovr_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Scoreboard bench for uart_alu_interface: random commands, reference ALU,
// overrun, reset and (with RX_TIMEOUT_EN) timeout scenarios.
module tb_uart_alu_interface;

    localparam int NB_DATA = 16;
    localparam int NB_OP   = 6;
    localparam int TMO     = 100;

    logic               clk = 1'b0;
    logic               i_reset;
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_valid;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_alu_a;
    logic [NB_DATA-1:0] o_alu_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_rx_overrun;
    logic               o_timeout;

    always #5 clk = ~clk;

    uart_alu_interface #(
        .NB_DATA(NB_DATA),
        .NB_OP(NB_OP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk),
        .i_reset(i_reset),
        .i_rx_data(i_rx_data),
        .i_rx_valid(i_rx_valid),
        .i_alu_result(i_alu_result),
        .i_tx_done(i_tx_done),
        .o_alu_a(o_alu_a),
        .o_alu_b(o_alu_b),
        .o_alu_op(o_alu_op),
        .o_tx_data(o_tx_data),
        .o_tx_start(o_tx_start),
        .o_busy(o_busy),
        .o_rx_overrun(o_rx_overrun),
        .o_timeout(o_timeout)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [5:0]  op;
        logic [15:0] res;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          errors  = 0;
    int          checks  = 0;
    int          cyc     = 0;
    int          to_seen = 0;
    int          to_cyc  = -1;
    logic [15:0] last_a;
    logic [15:0] last_res;

    function automatic logic [15:0] alu_f(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return a ^ {b[7:0], b[15:8]};
        endcase
    endfunction

    always_comb i_alu_result = alu_f(o_alu_a, o_alu_b, o_alu_op);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every transmit request must match the oldest expected command
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (o_timeout) begin
            to_seen++;
            to_cyc = cyc;
        end
        if (o_tx_start) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_start_unexpected: got start at cycle %0d expected none",
                         cyc);
            end else begin
                e = sbq.pop_front();
                chk("alu_a", o_alu_a, e.a);
                chk("alu_b", o_alu_b, e.b);
                chk("alu_op", o_alu_op, e.op);
                chk("tx_data", o_tx_data, e.res);
                chk("start_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w);
        i_rx_valid = 1'b1;
        i_rx_data  = w;
        tick();
        i_rx_valid = 1'b0;
        i_rx_data  = 16'($urandom);
    endtask

    // idle cycles with stray tx_done pulses, which must be ignored
    task automatic gap(input int n);
        repeat (n) begin
            i_tx_done = ($urandom_range(0, 3) == 0);
            tick();
        end
        i_tx_done = 1'b0;
    endtask

    task automatic send_op(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] opw);
        exp_t        e;
        logic [5:0]  op;
        op    = opw[5:0];
        e.a   = a;
        e.b   = b;
        e.op  = op;
        e.res = alu_f(a, b, op);
        e.cyc = cyc + 3;
        sbq.push_back(e);
        last_a   = a;
        last_res = e.res;
        send_word(opw);
    endtask

    task automatic send_cmd(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] opw, input int maxgap);
        send_word(a);
        gap($urandom_range(0, maxgap));
        send_word(b);
        gap($urandom_range(0, maxgap));
        send_op(a, b, opw);
    endtask

    task automatic finish_cmd(input int d);
        @(negedge clk);
        chk("busy_exec", o_busy, 1);
        tick();
        tick();
        repeat (d) tick();
        i_tx_done = 1'b1;
        @(negedge clk);
        chk("busy_wait_done", o_busy, 1);
        tick();
        i_tx_done = 1'b0;
        @(negedge clk);
        chk("busy_after_done", o_busy, 0);
        tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a"}, o_alu_a, 0);
        chk({tag, "_b"}, o_alu_b, 0);
        chk({tag, "_op"}, o_alu_op, 0);
        chk({tag, "_txd"}, o_tx_data, 0);
        chk({tag, "_start"}, o_tx_start, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_ovr"}, o_rx_overrun, 0);
        chk({tag, "_tmo"}, o_timeout, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int t0;
        i_reset    = 1'b1;
        i_rx_data  = '0;
        i_rx_valid = 1'b0;
        i_tx_done  = 1'b0;
        repeat (3) tick();
        i_reset = 1'b0;
        @(negedge clk);
        check_zero("reset");
        tick();

        send_cmd(16'h0005, 16'h0003, 16'h0020, 2);
        finish_cmd(3);
        chk("hold_a", o_alu_a, 16'h0005);
        chk("hold_txd", o_tx_data, 16'h0008);

        send_cmd(16'hFFFF, 16'h0001, 16'h00E0, 0);
        finish_cmd(0);

        for (int i = 0; i < 25; i++) begin
            send_cmd(16'($urandom), 16'($urandom), 16'($urandom), 3);
            finish_cmd($urandom_range(0, 4));
        end
        @(negedge clk);
        chk("overrun_clear", o_rx_overrun, 0);
        tick();

        send_cmd(16'h0A0A, 16'h0B0B, 16'h0026, 1);
        tick();
        tick();
        tick();
        i_tx_done  = 1'b1;
        i_rx_valid = 1'b1;
        i_rx_data  = 16'h1234;
        tick();
        i_tx_done  = 1'b0;
        i_rx_valid = 1'b0;
        @(negedge clk);
        chk("overrun_set", o_rx_overrun, 1);
        chk("overrun_idle", o_busy, 0);
        chk("overrun_a_kept", o_alu_a, 16'h0A0A);
        tick();
        send_cmd(16'h0102, 16'h0304, 16'h0022, 2);
        finish_cmd(1);
        chk("overrun_sticky", o_rx_overrun, 1);

        send_word(16'h1111);
        send_word(16'h2222);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        @(negedge clk);
        check_zero("rst_op");
        tick();
        send_cmd(16'h4444, 16'h5555, 16'h0025, 1);
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        @(negedge clk);
        check_zero("rst_done");
        tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        @(negedge clk);
        chk("rst_txdone_busy", o_busy, 0);
        tick();
        send_cmd(16'h0777, 16'h0111, 16'h0022, 2);
        finish_cmd(2);

`ifdef RX_TIMEOUT_EN
        c0 = cyc;
        t0 = to_seen;
        send_word(16'h0042);
        repeat (120) tick();
        chk("timeout_count", to_seen, t0 + 1);
        chk("timeout_cycle", to_cyc, c0 + TMO + 2);
        chk("timeout_busy", o_busy, 0);
        send_cmd(16'h0010, 16'h0020, 16'h0020, 2);
        finish_cmd(1);

        t0 = to_seen;
        send_word(16'h0011);
        repeat (TMO - 1) tick();
        send_word(16'h0022);
        send_op(16'h0011, 16'h0022, 16'h0024);
        finish_cmd(0);
        chk("terminal_accept", to_seen, t0);
`else
        c0 = cyc;
        send_word(16'h0777);
        repeat (10000) tick();
        chk("no_timeout", to_seen, 0);
        chk("no_timeout_busy", o_busy, 0);
        chk("no_timeout_a", o_alu_a, 16'h0777);
        send_word(16'h0333);
        send_op(16'h0777, 16'h0333, 16'h0022);
        finish_cmd(1);
        chk("long_wait_cycles", cyc - c0 >= 10000, 1);
`endif

        repeat (4) tick();
        chk("sb_empty", sbq.size(), 0);
        chk("final_a", o_alu_a, last_a);
        chk("final_txd", o_tx_data, last_res);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
